// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: run/halt sequencing, hazard stalls, flush strobes, ALU operand selects
// and saturating stall/flush counters for the 5-stage MIPS pipeline. Macro HAZ_FWD_EN enables forwarding.
module pipe_hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 4
) (
    input  logic             clkHI,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             br_taken,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwr,
    input  logic             ex_memrd,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_regwr,
    input  logic             wb_regwr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [2:0]       fwd_a,
    output logic [2:0]       fwd_b,
    output logic             done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } state_e;

    localparam int            DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);
    localparam logic [2:0]    SEL_IDEX   = 3'd0;
`ifdef HAZ_FWD_EN
    localparam logic [2:0]    SEL_MEM    = 3'd1;
    localparam logic [2:0]    SEL_WB     = 3'd2;
`endif

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hazard;
    logic active;
    logic branch;
    logic stall;

    // Register 0 is hard-wired to zero, so it can never carry a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                       input logic wr);
        return wr && (src != 5'd0) && (src == dst);
    endfunction

`ifdef HAZ_FWD_EN
    logic unused_inputs;
    assign unused_inputs = ex_regwr;

    // Only a load still in EX cannot be forwarded in time; everything else is bypassed.
    assign hazard = reg_match(id_rs, ex_rd, ex_memrd) | reg_match(id_rt, ex_rd, ex_memrd);

    function automatic logic [2:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] m_rd, input logic m_wr,
                                           input logic [4:0] w_rd, input logic w_wr);
        if (reg_match(src, m_rd, m_wr)) return SEL_MEM;
        if (reg_match(src, w_rd, w_wr)) return SEL_WB;
        return SEL_IDEX;
    endfunction

    assign fwd_a = fwd_sel(ex_rs, mem_rd, mem_regwr, wb_rd, wb_regwr);
    assign fwd_b = fwd_sel(ex_rt, mem_rd, mem_regwr, wb_rd, wb_regwr);
`else
    logic unused_inputs;
    assign unused_inputs = ^{ex_rs, ex_rt, ex_memrd};

    // Without bypassing, ID waits until every in-flight writer of its sources has retired.
    assign hazard = reg_match(id_rs, ex_rd,  ex_regwr)  | reg_match(id_rt, ex_rd,  ex_regwr)  |
                    reg_match(id_rs, mem_rd, mem_regwr) | reg_match(id_rt, mem_rd, mem_regwr) |
                    reg_match(id_rs, wb_rd,  wb_regwr)  | reg_match(id_rt, wb_rd,  wb_regwr);

    assign fwd_a = SEL_IDEX;
    assign fwd_b = SEL_IDEX;
`endif

    assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign branch = active && br_taken;
    // A taken branch squashes the stalled instruction anyway, so it wins.
    assign stall  = active && hazard && !br_taken;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (branch) begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end else if (stall) begin
                    ifid_flush  = 1'b0;
                    exmem_flush = 1'b0;
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b0;
                    idex_flush  = 1'b0;
                    exmem_flush = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (branch) begin
                    ifid_en = 1'b1;
                end else if (stall) begin
                    exmem_flush = 1'b0;
                end else begin
                    ifid_en     = 1'b1;
                    idex_flush  = 1'b0;
                    exmem_flush = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign done = (state_q == ST_HALT);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_HALT;
                else               drain_d = drain_q - DW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (branch && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clkHI or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed literal checks, then randomized
// stimulus compared every cycle against a behavioural model of the sequencing/hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W     = 4;
    localparam int DRAIN_CYC = 4;
    localparam int SAT       = (1 << CNT_W) - 1;

`ifdef HAZ_FWD_EN
    localparam int E_MEM       = 1;
    localparam int E_WB        = 2;
    localparam int E_RAW_PC    = 1;
    localparam int E_RAW_STALL = 0;
`else
    localparam int E_MEM       = 0;
    localparam int E_WB        = 0;
    localparam int E_RAW_PC    = 0;
    localparam int E_RAW_STALL = 3;
`endif

    logic clkHI = 1'b0;
    logic rst   = 1'b1;
    logic start, halt_req, br_taken;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic ex_regwr, ex_memrd, mem_regwr, wb_regwr;
    logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, done;
    logic [2:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clkHI(clkHI), .rst(rst), .start(start), .halt_req(halt_req), .br_taken(br_taken),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_regwr(mem_regwr), .wb_regwr(wb_regwr), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .done(done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clkHI = ~clkHI;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_HALT} mphase_e;
    mphase_e m_phase      = M_IDLE;
    int      m_drain_left = 0;
    int      m_stalls     = 0;
    int      m_flushes    = 0;

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    function automatic bit id_hazard();
        bit [4:0] srcs [2];
        bit [4:0] dsts [3];
        bit       wrs  [3];
        srcs = '{id_rs, id_rt};
        dsts = '{ex_rd, mem_rd, wb_rd};
        wrs  = '{ex_regwr, mem_regwr, wb_regwr};
`ifdef HAZ_FWD_EN
        foreach (srcs[i]) if (srcs[i] != 0 && ex_memrd && srcs[i] == ex_rd) return 1'b1;
`else
        foreach (srcs[i])
            foreach (dsts[j])
                if (srcs[i] != 0 && wrs[j] && srcs[i] == dsts[j]) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int fwd_code(input logic [4:0] src);
        if (src == 0) return 0;
`ifdef HAZ_FWD_EN
        if (mem_regwr && mem_rd == src) return 1;
        if (wb_regwr && wb_rd == src) return 2;
`endif
        return 0;
    endfunction

    function automatic bit in_pipe_phase();
        return (m_phase == M_RUN) || (m_phase == M_DRAIN);
    endfunction

    always @(posedge clkHI or negedge rst) begin
        if (!rst) begin
            m_phase      <= M_IDLE;
            m_drain_left <= 0;
            m_stalls     <= 0;
            m_flushes    <= 0;
        end else begin
            if (in_pipe_phase() && br_taken) m_flushes <= m_flushes + 1;
            else if (in_pipe_phase() && id_hazard()) m_stalls <= m_stalls + 1;
            case (m_phase)
                M_IDLE, M_HALT: if (start) m_phase <= M_RUN;
                M_RUN: if (halt_req) begin
                    m_phase      <= M_DRAIN;
                    m_drain_left <= DRAIN_CYC;
                end
                M_DRAIN: begin
                    m_drain_left <= m_drain_left - 1;
                    if (m_drain_left == 1) m_phase <= M_HALT;
                end
                default: ;
            endcase
        end
    end

    bit e_pc, e_ifen, e_fif, e_fidex, e_fexmem;

    always @(negedge clkHI) begin
        e_pc = 0; e_ifen = 0; e_fif = 1; e_fidex = 1; e_fexmem = 1;
        if (m_phase == M_RUN) begin
            if (br_taken) begin
                e_pc = 1; e_ifen = 1;
            end else if (id_hazard()) begin
                e_fif = 0; e_fexmem = 0;
            end else begin
                e_pc = 1; e_ifen = 1; e_fif = 0; e_fidex = 0; e_fexmem = 0;
            end
        end else if (m_phase == M_DRAIN) begin
            if (br_taken) begin
                e_ifen = 1;
            end else if (id_hazard()) begin
                e_fexmem = 0;
            end else begin
                e_ifen = 1; e_fidex = 0; e_fexmem = 0;
            end
        end
        check("cyc_pc_en",       32'(pc_en),       32'(e_pc));
        check("cyc_ifid_en",     32'(ifid_en),     32'(e_ifen));
        check("cyc_ifid_flush",  32'(ifid_flush),  32'(e_fif));
        check("cyc_idex_flush",  32'(idex_flush),  32'(e_fidex));
        check("cyc_exmem_flush", 32'(exmem_flush), 32'(e_fexmem));
        check("cyc_fwd_a",       32'(fwd_a),       32'(fwd_code(ex_rs)));
        check("cyc_fwd_b",       32'(fwd_b),       32'(fwd_code(ex_rt)));
        check("cyc_done",        32'(done),        32'(m_phase == M_HALT));
        check("cyc_stall_cnt",   32'(stall_cnt),   32'(sat(m_stalls)));
        check("cyc_flush_cnt",   32'(flush_cnt),   32'(sat(m_flushes)));
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        start = 0; halt_req = 0; br_taken = 0;
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_regwr = 0; ex_memrd = 0; mem_regwr = 0; wb_regwr = 0;
    endtask

    task automatic next_cycle();
        @(posedge clkHI);
        #1;
    endtask

    initial begin
        clear_inputs();
        #1 rst = 1'b0;
        #1;
        check("rst_pc_en",       32'(pc_en), 0);
        check("rst_ifid_en",     32'(ifid_en), 0);
        check("rst_ifid_flush",  32'(ifid_flush), 1);
        check("rst_idex_flush",  32'(idex_flush), 1);
        check("rst_exmem_flush", 32'(exmem_flush), 1);
        check("rst_fwd_a",       32'(fwd_a), 0);
        check("rst_fwd_b",       32'(fwd_b), 0);
        check("rst_done",        32'(done), 0);
        check("rst_stall_cnt",   32'(stall_cnt), 0);
        check("rst_flush_cnt",   32'(flush_cnt), 0);
        #10 rst = 1'b1;

        next_cycle(); #3;
        check("idle_pc_en", 32'(pc_en), 0);
        next_cycle(); start = 1; #3;
        check("start_cycle_pc_en", 32'(pc_en), 0);
        next_cycle(); start = 0; #3;
        check("run_pc_en",       32'(pc_en), 1);
        check("run_ifid_en",     32'(ifid_en), 1);
        check("run_flushes",     32'({ifid_flush, idex_flush, exmem_flush}), 0);

        // load-use: producer load in EX feeding id_rs
        next_cycle(); ex_memrd = 1; ex_regwr = 1; ex_rd = 5; id_rs = 5; #3;
        check("lu_pc_en",      32'(pc_en), 0);
        check("lu_ifid_en",    32'(ifid_en), 0);
        check("lu_idex_flush", 32'(idex_flush), 1);
        next_cycle(); clear_inputs(); #3;
        check("lu_release_pc_en", 32'(pc_en), 1);
        check("lu_stall_cnt",     32'(stall_cnt), 1);

        // forwarding priority
        next_cycle(); ex_rs = 3; ex_rt = 3; mem_rd = 3; mem_regwr = 1; wb_rd = 3; wb_regwr = 1; #1;
        check("fwd_a_mem", 32'(fwd_a), E_MEM);
        check("fwd_b_mem", 32'(fwd_b), E_MEM);
        mem_regwr = 0; #1;
        check("fwd_a_wb", 32'(fwd_a), E_WB);
        ex_rs = 0; #1;
        check("fwd_a_r0", 32'(fwd_a), 0);

        // branch overrides a simultaneous load-use
        next_cycle(); clear_inputs();
        ex_memrd = 1; ex_regwr = 1; ex_rd = 9; id_rt = 9; br_taken = 1; #3;
        check("br_flushes", 32'({ifid_flush, idex_flush, exmem_flush}), 7);
        check("br_pc_en",   32'(pc_en), 1);
        next_cycle(); clear_inputs(); #3;
        check("br_flush_cnt", 32'(flush_cnt), 1);
        check("br_stall_cnt", 32'(stall_cnt), 1);

        // dependent ALU pair: producer advances EX -> MEM -> WB
        next_cycle(); ex_regwr = 1; ex_rd = 7; id_rt = 7; #3;
        check("raw_ex_pc_en", 32'(pc_en), E_RAW_PC);
        check("raw_ex_fwd_b", 32'(fwd_b), 0);
        next_cycle(); ex_regwr = 0; ex_rd = 0; mem_regwr = 1; mem_rd = 7; #3;
        check("raw_mem_pc_en", 32'(pc_en), E_RAW_PC);
        next_cycle(); mem_regwr = 0; mem_rd = 0; wb_regwr = 1; wb_rd = 7; #3;
        check("raw_wb_pc_en", 32'(pc_en), E_RAW_PC);
        next_cycle(); clear_inputs(); #3;
        check("raw_done_pc_en", 32'(pc_en), 1);
        check("raw_stall_cnt",  32'(stall_cnt), 1 + E_RAW_STALL);

        // halt: drain then HALT, then restart
        next_cycle(); halt_req = 1; #3;
        check("halt_req_pc_en", 32'(pc_en), 1);
        for (int i = 0; i < DRAIN_CYC; i++) begin
            next_cycle(); halt_req = 0; #3;
            check("drain_ifid_flush", 32'(ifid_flush), 1);
            check("drain_pc_en",      32'(pc_en), 0);
            check("drain_done",       32'(done), 0);
        end
        next_cycle(); #3;
        check("halt_done",  32'(done), 1);
        check("halt_pc_en", 32'(pc_en), 0);
        next_cycle(); start = 1; halt_req = 1; #3;
        check("halt_start_done", 32'(done), 1);
        next_cycle(); start = 0; halt_req = 0; #3;
        check("restart_pc_en", 32'(pc_en), 1);
        check("restart_done",  32'(done), 0);

        // randomized phase, with one asynchronous reset mid-run
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (c == 1500) begin
                #1 rst = 1'b0;
                #1;
                check("midrst_pc_en",      32'(pc_en), 0);
                check("midrst_ifid_flush", 32'(ifid_flush), 1);
                check("midrst_done",       32'(done), 0);
                check("midrst_stall_cnt",  32'(stall_cnt), 0);
                check("midrst_flush_cnt",  32'(flush_cnt), 0);
                #4 rst = 1'b1;
            end
            start     = ($urandom_range(0, 7) == 0);
            halt_req  = ($urandom_range(0, 19) == 0);
            br_taken  = in_pipe_phase() && ($urandom_range(0, 7) == 0);
            id_rs     = 5'($urandom_range(0, 3));
            id_rt     = 5'($urandom_range(0, 3));
            ex_rs     = 5'($urandom_range(0, 3));
            ex_rt     = 5'($urandom_range(0, 3));
            ex_rd     = 5'($urandom_range(0, 3));
            mem_rd    = 5'($urandom_range(0, 3));
            wb_rd     = 5'($urandom_range(0, 3));
            ex_regwr  = 1'($urandom_range(0, 1));
            ex_memrd  = 1'($urandom_range(0, 1));
            mem_regwr = 1'($urandom_range(0, 1));
            wb_regwr  = 1'($urandom_range(0, 1));
        end

        next_cycle(); clear_inputs();
        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
